regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/waddr/wdata) among NREQ writeback requesters, such as the ALU result, the load return and the multi-cycle mul/div unit.
- Arbitration is round-robin with a valid/ready handshake, followed by a registered output stage that drives the regfile write port directly.
- A pending-write scoreboard (one bit per register) gives the issue stage a busy indication for its two read addresses, so it can stall until a producer has written back.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter sharing the single register-file write port among
//   NREQ writeback requesters, followed by a registered output stage that
//   drives the regfile directly. A per-register pending-write scoreboard
//   gives the issue stage busy flags for its two read addresses.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is one-hot)
//   req_waddr/wdata     packed per-requester address/data ([i*W +: W])
//   we/waddr/wdata      registered regfile write port
//   alloc_valid/addr    issue-stage destination allocation
//   raddr1/2, busy1/2   issue-stage read addresses and their busy flags
//   err                 sticky protocol-error flag
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic               we,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata,
    input  logic               alloc_valid,
    input  logic [AW-1:0]      alloc_addr,
    input  logic [AW-1:0]      raddr1,
    input  logic [AW-1:0]      raddr2,
    output logic               busy1,
    output logic               busy2,
    output logic               err
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic            err_q, err_d;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic            alloc_err;
    logic            wr_err;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
        if (!rst) gnt_any = 1'b0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign gnt_addr = req_waddr[gnt_idx*AW +: AW];
    assign gnt_data = req_wdata[gnt_idx*DW +: DW];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        // A grant to r0 is consumed but never turns into a regfile write.
        we_d     = gnt_any && (gnt_addr != '0);
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            waddr_d  = gnt_addr;
            wdata_d  = gnt_data;
        end
    end

    // Clear for the write leaving the output stage first, so an allocation
    // of the same register on the same edge wins.
    always_comb begin
        pend_d = pend_q;
        if (we_q) pend_d[waddr_q] = 1'b0;
        if (alloc_valid && (alloc_addr != '0)) pend_d[alloc_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    assign alloc_err = alloc_valid && pend_q[alloc_addr] &&
                       !(we_q && (waddr_q == alloc_addr));
    assign wr_err    = we_q && !pend_q[waddr_q];
    assign err_d     = err_q || alloc_err || wr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    // The write in the output stage is forwarded by the regfile, so its
    // target is already readable this cycle.
    assign busy1 = (raddr1 != '0) && pend_q[raddr1] && !(we_q && (waddr_q == raddr1));
    assign busy2 = (raddr2 != '0) && pend_q[raddr2] && !(we_q && (waddr_q == raddr2));

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_waddr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic               alloc_valid;
    logic [AW-1:0]      alloc_addr;
    logic [AW-1:0]      raddr1;
    logic [AW-1:0]      raddr2;
    logic               busy1;
    logic               busy2;
    logic               err;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc_valid(alloc_valid),
        .alloc_addr (alloc_addr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the architectural state the spec describes.
    int          m_ptr;
    bit          m_pend [32];
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_known;
    bit          m_err;
    int          m_g;

    // Outputs sampled during the last step.
    logic [NREQ-1:0] s_ready;
    logic            s_we;
    logic [AW-1:0]   s_waddr;
    logic [DW-1:0]   s_wdata;
    logic            s_busy1, s_busy2, s_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_we    = 0;
        m_waddr = 0;
        m_wdata = '0;
        m_known = 1;
        m_err   = 0;
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
    endtask

    function automatic bit exp_busy(input int ra);
        return (ra != 0) && m_pend[ra] && !(m_we && (m_waddr == ra));
    endfunction

    // One clock cycle: inputs were driven just after the previous rising
    // edge; check at the falling edge, then advance the model.
    task automatic step();
        int g;
        int ga;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        if (!rst) model_reset();
        g = -1;
        if (rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        s_ready = req_ready; s_we = we; s_waddr = waddr; s_wdata = wdata;
        s_busy1 = busy1; s_busy2 = busy2; s_err = err;

        chk("ready", 64'(req_ready), 64'(exp_rdy));
        chk("we", 64'(we), 64'(m_we));
        if (m_we || m_known) begin
            chk("waddr", 64'(waddr), 64'(m_waddr));
            chk("wdata", 64'(wdata), 64'(m_wdata));
        end
        chk("busy1", 64'(busy1), 64'(exp_busy(int'(raddr1))));
        chk("busy2", 64'(busy2), 64'(exp_busy(int'(raddr2))));
        chk("err", 64'(err), 64'(m_err));

        m_g = g;
        if (rst) begin
            if (alloc_valid && m_pend[alloc_addr] && !(m_we && m_waddr == int'(alloc_addr)))
                m_err = 1;
            if (m_we && !m_pend[m_waddr]) m_err = 1;
            if (m_we) m_pend[m_waddr] = 0;
            if (alloc_valid && alloc_addr != 0) m_pend[alloc_addr] = 1;
            if (g >= 0) begin
                ga      = int'(req_waddr[g*AW +: AW]);
                m_we    = (ga != 0);
                m_waddr = ga;
                m_wdata = req_wdata[g*DW +: DW];
                m_known = (ga != 0);
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_we = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid   = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        raddr1      = '0;
        raddr2      = '0;
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d);
        req_waddr[i*AW +: AW] = AW'(a);
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    bit held [NREQ];

    initial begin
        rst       = 1'b0;
        req_waddr = '0;
        req_wdata = '0;
        idle();
        model_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 32'h1000_0000 + 32'(i));

        // Reset with every requester valid.
        req_valid = 3'b111;
        raddr1 = 5'd1; raddr2 = 5'd2;
        step();
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_we", 64'(s_we), 64'd0);
        chk("rst_busy", 64'({s_busy1, s_busy2}), 64'd0);
        chk("rst_err", 64'(s_err), 64'd0);

        // Round-robin over six cycles.
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rr_gnt", 64'(s_ready), 64'(1 << (c % NREQ)));
            if (c > 0) begin
                chk("rr_we", 64'(s_we), 64'd1);
                chk("rr_waddr", 64'(s_waddr), 64'(((c - 1) % NREQ) + 1));
                chk("rr_wdata", 64'(s_wdata), 64'(32'h1000_0000 + 32'((c - 1) % NREQ)));
            end
        end
        do_reset();

        // Latency and bypass on r5.
        idle(); raddr1 = 5'd5; alloc_valid = 1'b1; alloc_addr = 5'd5;
        step();
        idle(); raddr1 = 5'd5; req_valid = 3'b010; set_req(1, 5, 32'hDEAD_BEEF);
        step();
        chk("byp_gnt", 64'(s_ready), 64'h2);
        chk("byp_busy_pend", 64'(s_busy1), 64'd1);
        idle(); raddr1 = 5'd5;
        step();
        chk("byp_we", 64'(s_we), 64'd1);
        chk("byp_waddr", 64'(s_waddr), 64'd5);
        chk("byp_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("byp_busy_out", 64'(s_busy1), 64'd0);
        step();
        chk("byp_busy_after", 64'(s_busy1), 64'd0);
        chk("byp_err", 64'(s_err), 64'd0);

        // Set and clear of r7 on the same edge.
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd7;
        step();
        idle(); req_valid = 3'b001; set_req(0, 7, 32'h0000_7777);
        step();
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd7; raddr2 = 5'd7;
        step();
        chk("sc_we", 64'(s_we), 64'd1);
        chk("sc_busy_out", 64'(s_busy2), 64'd0);
        idle(); raddr2 = 5'd7;
        step();
        chk("sc_busy", 64'(s_busy2), 64'd1);
        chk("sc_err", 64'(s_err), 64'd0);
        idle(); req_valid = 3'b001;
        step();
        idle();
        step();
        step();
        chk("sc_drain_busy", 64'(s_busy2), 64'd0);

        // Register zero.
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd0; req_valid = 3'b100; set_req(2, 0, 32'h1234_5678);
        step();
        chk("r0_gnt", 64'(s_ready), 64'h4);
        idle();
        step();
        chk("r0_we", 64'(s_we), 64'd0);
        chk("r0_busy", 64'(s_busy1), 64'd0);
        step();
        chk("r0_err", 64'(s_err), 64'd0);

        // Double allocation of r3.
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd3;
        step();
        step();
        idle();
        step();
        chk("dbl_err", 64'(s_err), 64'd1);
        step();
        chk("dbl_err_sticky", 64'(s_err), 64'd1);
        do_reset();

        // Unallocated write to r9.
        idle(); req_valid = 3'b001; set_req(0, 9, 32'h9999_9999);
        step();
        idle();
        step();
        chk("wr9_we", 64'(s_we), 64'd1);
        chk("wr9_err_pre", 64'(s_err), 64'd0);
        step();
        chk("wr9_err", 64'(s_err), 64'd1);
        do_reset();

        // Randomised traffic with occasional mid-operation resets.
        for (int i = 0; i < NREQ; i++) held[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!held[i] && $urandom_range(0, 1) == 1) begin
                    held[i] = 1;
                    set_req(i, int'($urandom_range(0, 7)), $urandom);
                end
                req_valid[i] = held[i];
            end
            rst         = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_addr  = AW'($urandom_range(0, 7));
            raddr1      = AW'($urandom_range(0, 7));
            raddr2      = AW'($urandom_range(0, 7));
            step();
            if (m_g >= 0) held[m_g] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
